// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single synchronous memory.
// Runs one transaction at a time: IDLE -> ACC (strobe) -> RESP (ready pulse, re-arbitrate).
module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic [15:0]   conflicts
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic          owner;      // 1 = data port owns the in-flight transaction
    logic          cmd_we;
    logic          last_data;  // 1 = data port was granted most recently
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] i_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic [15:0]   conflict_cnt;

    logic i_elig;
    logic d_elig;
    logic both_elig;
    logic grant;
    logic grant_data;

    // In RESP the owner has just been served, so only the other port may win.
    always_comb begin
        i_elig     = i_req && ((state == IDLE) || ((state == RESP) && owner));
        d_elig     = d_req && ((state == IDLE) || ((state == RESP) && !owner));
        both_elig  = i_elig && d_elig;
        grant      = i_elig || d_elig;
        grant_data = d_elig;
        if (both_elig) begin
            grant_data = DATA_PRIO ? 1'b1 : !last_data;
        end
    end

    // Strobes and ready pulses decode straight from state so reset kills them at once.
    assign m_en    = (state == ACC);
    assign m_we    = (state == ACC) && cmd_we;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign i_ready = (state == RESP) && !owner;
    assign d_ready = (state == RESP) && owner;
    assign i_rdata = i_ready ? m_rdata : i_rdata_q;
    assign d_rdata = (d_ready && !cmd_we) ? m_rdata : d_rdata_q;
    assign conflicts = conflict_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= 1'b0;
            cmd_we       <= 1'b0;
            last_data    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant) begin
                state     <= ACC;
                owner     <= grant_data;
                cmd_we    <= grant_data && d_we;
                last_data <= grant_data;
                addr_q    <= grant_data ? d_addr : i_addr;
                if (grant_data) begin
                    wdata_q <= d_wdata;
                end
            end else if (state == ACC) begin
                state <= RESP;
            end else begin
                state <= IDLE;
            end

            if (i_ready) begin
                i_rdata_q <= m_rdata;
            end
            if (d_ready && !cmd_we) begin
                d_rdata_q <= m_rdata;
            end

            if (both_elig && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule
